// File: rtl/tile_blitter_if.sv
// tile_blitter_if: groups the draw-request, ROM read and VGA write signals
// of the tile blitter into one bundle.
//   go, X, Y, memory_select, tile_select : draw request from the datapath
//   rom_addr, rom_sel / rom_data         : ROM read port (address out, colour back)
//   X_out, Y_out, colour, write_en       : VGA adapter write port
//   busy, finished                       : status back to the datapath
// master: the environment (datapath, ROM, VGA adapter); slave: the blitter.
interface tile_blitter_if;
  logic        go;
  logic [8:0]  X;
  logic [7:0]  Y;
  logic [1:0]  memory_select;
  logic [3:0]  tile_select;
  logic [16:0] rom_addr;
  logic [1:0]  rom_sel;
  logic [2:0]  rom_data;
  logic [8:0]  X_out;
  logic [7:0]  Y_out;
  logic [2:0]  colour;
  logic        write_en;
  logic        busy;
  logic        finished;

  modport master (
    output go, X, Y, memory_select, tile_select, rom_data,
    input  rom_addr, rom_sel, X_out, Y_out, colour, write_en, busy, finished
  );

  modport slave (
    input  go, X, Y, memory_select, tile_select, rom_data,
    output rom_addr, rom_sel, X_out, Y_out, colour, write_en, busy, finished
  );
endinterface

// File: rtl/tile_blitter.sv
// tile_blitter: copies a 16x16 sprite tile or a full-screen image from
// on-chip ROM to the VGA adapter write port, one pixel per clock.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high
//   bus   : tile_blitter_if.slave (draw request, ROM read port, VGA write
//           port, busy/finished status)
// A copy of N pixels takes N+2 cycles from the accepted go edge to the
// one-cycle finished pulse; clipped and transparent pixels still take
// their cycle.
module tile_blitter #(
  parameter logic [2:0] TRANSPARENT = 3'b101,
  parameter int         SCREEN_W    = 320,
  parameter int         SCREEN_H    = 240
) (
  input  logic          clock,
  input  logic          reset,
  tile_blitter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [8:0] W_LIM      = 9'(SCREEN_W);
  localparam logic [7:0] H_LIM      = 8'(SCREEN_H);
  localparam logic [8:0] LAST_X_SCR = 9'(SCREEN_W - 1);
  localparam logic [7:0] LAST_Y_SCR = 8'(SCREEN_H - 1);
  localparam logic [8:0] LAST_X_TIL = 9'd15;
  localparam logic [7:0] LAST_Y_TIL = 8'd15;

  state_t state, state_next;

  // latched operands and raster counters
  logic [8:0] x_base;
  logic [7:0] y_base;
  logic [1:0] sel;
  logic [3:0] tile;
  logic [8:0] rx;
  logic [7:0] ry;
  logic       drain_cnt;

  logic       full_src;
  logic [8:0] last_x;
  logic [7:0] last_y;
  logic       row_end;
  logic       last_pix;
  logic       vld_p0;

  // stage 1 and stage 2 pipeline registers
  logic       vld_p1;
  logic [8:0] rx_p1;
  logic [7:0] ry_p1;
  logic [8:0] x_p2;
  logic [7:0] y_p2;
  logic [2:0] colour_p2;
  logic       we_p2;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       busy_c;
  logic       finished_c;

  // Full-screen address is ry*320+rx built from two shifts and an add.
  function automatic logic [16:0] rom_address(input logic       full,
                                              input logic [3:0] t,
                                              input logic [8:0] x,
                                              input logic [7:0] y);
    logic [16:0] y17;
    y17 = {9'd0, y};
    if (full)
      return (y17 << 8) + (y17 << 6) + {8'd0, x};
    else
      return {5'b0, t, y[3:0], x[3:0]};
  endfunction

  function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
    return (x < W_LIM) && (y < H_LIM);
  endfunction

  assign full_src = (sel != 2'd1);
  assign last_x   = full_src ? LAST_X_SCR : LAST_X_TIL;
  assign last_y   = full_src ? LAST_Y_SCR : LAST_Y_TIL;
  assign row_end  = (rx == last_x);
  assign last_pix = row_end && (ry == last_y);
  assign vld_p0   = (state == RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b1;
    finished_c = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.go) state_next = RUN;
      end
      RUN:   if (last_pix) state_next = DRAIN;
      DRAIN: if (drain_cnt) state_next = DONE;
      DONE: begin
        finished_c = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch and raster counters. Full-screen sources always draw at
  // the origin, so their destination is forced to 0 at the latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_base    <= '0;
      y_base    <= '0;
      sel       <= '0;
      tile      <= '0;
      rx        <= '0;
      ry        <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drain_cnt <= 1'b0;
          if (bus.go) begin
            sel    <= bus.memory_select;
            tile   <= bus.tile_select;
            x_base <= (bus.memory_select == 2'd1) ? bus.X : 9'd0;
            y_base <= (bus.memory_select == 2'd1) ? bus.Y : 8'd0;
            rx     <= '0;
            ry     <= '0;
          end
        end
        RUN: begin
          drain_cnt <= 1'b0;
          if (row_end) begin
            rx <= '0;
            if (!last_pix) ry <= ry + 8'd1;
          end else begin
            rx <= rx + 9'd1;
          end
        end
        DRAIN:   drain_cnt <= 1'b1;
        default: drain_cnt <= 1'b0;
      endcase
    end
  end

  // ---- stage 1: coordinates travel with the ROM access ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clock) begin
    rx_p1 <= rx;
    ry_p1 <= ry;
  end

  // ---- stage 2: screen position, colour and plot strobe ----
  assign x_sum = x_base + rx_p1;
  assign y_sum = y_base + ry_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_p2      <= '0;
      y_p2      <= '0;
      colour_p2 <= '0;
      we_p2     <= 1'b0;
    end else begin
      x_p2      <= x_sum;
      y_p2      <= y_sum;
      colour_p2 <= bus.rom_data;
      we_p2     <= vld_p1 && on_screen(x_sum, y_sum) &&
                   (full_src || (bus.rom_data != TRANSPARENT));
    end
  end

  assign bus.rom_addr = rom_address(full_src, tile, rx, ry);
  assign bus.rom_sel  = sel;
  assign bus.X_out    = x_p2;
  assign bus.Y_out    = y_p2;
  assign bus.colour   = colour_p2;
  assign bus.write_en = we_p2;
  assign bus.busy     = busy_c;
  assign bus.finished = finished_c;

endmodule

// File: tb/tb_tile_blitter.sv
// tb_tile_blitter: directed bench for tile_blitter with a behavioural
// pixel model, a ROM model and per-cycle output comparison.
module tb_tile_blitter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tile_blitter_if bus ();

  tile_blitter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  int  go_cyc = 0;
  bit  chk_en = 1'b0;
  int  wr_cnt = 0;
  int  m_sel, m_tile, m_x, m_y, m_n;

  int  cmp_k, cmp_x, cmp_y, cmp_c;
  bit  cmp_we;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ROM contents: bank 1 holds tiles (no transparent key except the even
  // columns of tile 10); other banks hold full-screen images.
  function automatic int rom_word(input int sel, input int addr);
    int c;
    if (sel == 1) begin
      if (((addr >> 8) & 15) == 10 && (addr & 1) == 0) return 5;
      c = (addr ^ (addr >> 4) ^ (addr >> 8)) & 7;
      if (c == 5) c = 2;
      return c;
    end
    return (addr + 3 * sel) & 7;
  endfunction

  // Expected plot for pixel n of the current copy, from raster order.
  function automatic void model_pix(input int n, output int ex, output int ey,
                                    output int ec, output bit we);
    bit full;
    int w, px, py, bx, by, addr;
    full = (m_sel != 1);
    w    = full ? 320 : 16;
    px   = n % w;
    py   = n / w;
    bx   = full ? 0 : m_x;
    by   = full ? 0 : m_y;
    ex   = (bx + px) % 512;
    ey   = (by + py) % 256;
    addr = full ? py * 320 + px : m_tile * 256 + py * 16 + px;
    ec   = rom_word(m_sel, addr);
    we   = (ex < 320) && (ey < 240) && (full || ec != 5);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock)
    bus.rom_data <= 3'(rom_word(int'(bus.rom_sel), int'(bus.rom_addr)));

  always @(negedge clock) begin
    if (chk_en) begin
      cmp_k  = cyc - go_cyc;
      cmp_we = 1'b0;
      cmp_x  = 0;
      cmp_y  = 0;
      cmp_c  = 0;
      if (cmp_k >= 2 && cmp_k - 2 < m_n) model_pix(cmp_k - 2, cmp_x, cmp_y, cmp_c, cmp_we);
      check("write_en", int'(bus.write_en), int'(cmp_we));
      if (cmp_we && bus.write_en) begin
        check("X_out", int'(bus.X_out), cmp_x);
        check("Y_out", int'(bus.Y_out), cmp_y);
        check("colour", int'(bus.colour), cmp_c);
      end
      if (bus.write_en) begin
        wr_cnt++;
        check("clip", int'(bus.X_out < 9'd320 && bus.Y_out < 8'd240), 1);
      end
      check("finished", int'(bus.finished), int'(cmp_k == m_n + 2));
      check("busy", int'(bus.busy), int'(cmp_k >= 0 && cmp_k <= m_n + 2));
    end
  end

  // Issue one go and step through the copy. second_go > 0 pulses go again
  // at that edge; abort_at > 0 stops after edge abort_at-1 with checks off.
  task automatic run_copy(input int sel, input int tile, input int x, input int y,
                          input int second_go, input int abort_at,
                          output int writes, output int first_x, output int first_y,
                          output int last_x, output int last_y, output int last_we,
                          output int fin_lit);
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; last_we = -1; fin_lit = -1;
    @(negedge clock);
    bus.go            = 1'b1;
    bus.memory_select = 2'(sel);
    bus.tile_select   = 4'(tile);
    bus.X             = 9'(x);
    bus.Y             = 8'(y);
    m_sel  = sel;
    m_tile = tile;
    m_x    = x;
    m_y    = y;
    m_n    = (sel == 1) ? 256 : 76800;
    go_cyc = cyc + 1;
    wr_cnt = 0;
    chk_en = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    for (int k = 1; k <= m_n + 3; k++) begin
      @(negedge clock);
      if (abort_at > 0 && k == abort_at - 1) begin
        chk_en = 1'b0;
        break;
      end
      if (second_go > 0 && k == second_go - 1) bus.go = 1'b1;
      if (second_go > 0 && k == second_go) bus.go = 1'b0;
      if (k == 2) begin
        first_x = int'(bus.X_out);
        first_y = int'(bus.Y_out);
      end
      if (k == m_n + 1) begin
        last_x  = int'(bus.X_out);
        last_y  = int'(bus.Y_out);
        last_we = int'(bus.write_en);
      end
      if (k == m_n + 2) fin_lit = int'(bus.finished);
    end
    chk_en = 1'b0;
    writes = wr_cnt;
  endtask

  int wr, fx, fy, lx, ly, lwe, fin, bad;

  initial begin
    bus.go            = 1'b0;
    bus.X             = '0;
    bus.Y             = '0;
    bus.memory_select = '0;
    bus.tile_select   = '0;
    reset             = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_X_out", int'(bus.X_out), 0);
    check("rst_Y_out", int'(bus.Y_out), 0);
    check("rst_colour", int'(bus.colour), 0);
    check("rst_write_en", int'(bus.write_en), 0);
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    check("rst_rom_sel", int'(bus.rom_sel), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_finished", int'(bus.finished), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // plain tile copy
    run_copy(1, 12, 72, 32, 0, 0, wr, fx, fy, lx, ly, lwe, fin);
    check("tile_writes", wr, 256);
    check("tile_first_x", fx, 72);
    check("tile_first_y", fy, 32);
    check("tile_last_x", lx, 87);
    check("tile_last_y", ly, 47);
    check("tile_last_we", lwe, 1);
    check("tile_fin_258", fin, 1);

    // transparency: even columns of tile 10 are the key colour
    run_copy(1, 10, 40, 100, 0, 0, wr, fx, fy, lx, ly, lwe, fin);
    check("transp_writes", wr, 128);
    check("transp_fin_258", fin, 1);

    // clipping at the bottom-right corner
    run_copy(1, 3, 312, 232, 0, 0, wr, fx, fy, lx, ly, lwe, fin);
    check("clip_writes", wr, 64);
    check("clip_last_we", lwe, 0);

    // second go during the copy is ignored
    run_copy(1, 5, 200, 60, 50, 0, wr, fx, fy, lx, ly, lwe, fin);
    check("busy_go_writes", wr, 256);
    check("busy_go_fin", fin, 1);

    // full screen with a non-zero X supplied
    run_copy(0, 0, 100, 50, 0, 0, wr, fx, fy, lx, ly, lwe, fin);
    check("full_writes", wr, 76800);
    check("full_first_x", fx, 0);
    check("full_first_y", fy, 0);
    check("full_last_x", lx, 319);
    check("full_last_y", ly, 239);
    check("full_last_we", lwe, 1);
    check("full_fin_76802", fin, 1);

    // reset in the middle of a copy
    run_copy(1, 7, 10, 10, 0, 100, wr, fx, fy, lx, ly, lwe, fin);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_X_out", int'(bus.X_out), 0);
    check("abort_Y_out", int'(bus.Y_out), 0);
    check("abort_colour", int'(bus.colour), 0);
    check("abort_write_en", int'(bus.write_en), 0);
    check("abort_rom_addr", int'(bus.rom_addr), 0);
    check("abort_rom_sel", int'(bus.rom_sel), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_finished", int'(bus.finished), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clock);
      if (bus.finished || bus.write_en || bus.busy) bad++;
    end
    check("abort_quiet", bad, 0);

    // normal copy after the abort
    run_copy(1, 12, 0, 0, 0, 0, wr, fx, fy, lx, ly, lwe, fin);
    check("post_reset_writes", wr, 256);
    check("post_reset_last_x", lx, 15);
    check("post_reset_fin", fin, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
